// File: rtl/adder_arbiter_pkg.sv
// Shared defaults and requester-id type for the two-port arbitrated adder.
// No logic here; latency and backpressure do not apply.
package adder_arbiter_pkg;

    localparam int W_DEF      = 4;
    localparam int LAT_DEF    = 4;
    localparam int FDEPTH_DEF = 2;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/pipelined_ripple_carry.sv
// Ripple-carry adder cut into LAT register stages, roughly W/LAT bits per stage.
// Latency LAT cycles from A/B/carry_in to Sum/carry_out; never stalls, no backpressure.
module pipelined_ripple_carry
    import adder_arbiter_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic         clk,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         carry_in,
    output logic [W-1:0] Sum,
    output logic         carry_out
);

    // Per-stage inputs (operands, partial sum, running carry) and stage results.
    logic [LAT-1:0][W-1:0] w_a_st;
    logic [LAT-1:0][W-1:0] w_b_st;
    logic [LAT-1:0][W-1:0] w_s_st;
    logic [LAT-1:0]        w_c_st;
    logic [LAT-1:0][W-1:0] w_s_nx;
    logic [LAT-1:0]        w_c_nx;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int LO = (k * W) / LAT;
        localparam int HI = ((k + 1) * W) / LAT;

        logic [W-1:0] w_s_t;
        logic         w_c_t;

        if (k == 0) begin : g_in
            assign w_a_st[k] = A;
            assign w_b_st[k] = B;
            assign w_s_st[k] = '0;
            assign w_c_st[k] = carry_in;
        end else begin : g_reg
            logic [W-1:0] r_a;
            logic [W-1:0] r_b;
            logic [W-1:0] r_s;
            logic         r_c;

            always_ff @(posedge clk) begin
                r_a <= w_a_st[k-1];
                r_b <= w_b_st[k-1];
                r_s <= w_s_nx[k-1];
                r_c <= w_c_nx[k-1];
            end

            assign w_a_st[k] = r_a;
            assign w_b_st[k] = r_b;
            assign w_s_st[k] = r_s;
            assign w_c_st[k] = r_c;
        end

        // Only the bit slice [LO, HI) is resolved here; other bits pass through.
        always_comb begin
            w_s_t = w_s_st[k];
            w_c_t = w_c_st[k];
            for (int i = 0; i < W; i++) begin
                if (i >= LO && i < HI) begin
                    w_s_t[i] = w_a_st[k][i] ^ w_b_st[k][i] ^ w_c_t;
                    w_c_t    = (w_a_st[k][i] & w_b_st[k][i]) |
                               (w_c_t & (w_a_st[k][i] ^ w_b_st[k][i]));
                end
            end
        end

        assign w_s_nx[k] = w_s_t;
        assign w_c_nx[k] = w_c_t;
    end

    always_ff @(posedge clk) begin
        Sum       <= w_s_nx[LAT-1];
        carry_out <= w_c_nx[LAT-1];
    end

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one pipelined adder via round-robin; results return through per-requester FIFOs.
// Handshake in cycle t gives rsp valid in t+LAT+1; backpressure only through per-requester credits (FDEPTH).
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int LAT    = LAT_DEF,
    parameter int FDEPTH = FDEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_sum,
    output logic         rsp0_cout,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_sum,
    output logic         rsp1_cout,
    output logic         busy
);

    localparam int CW = $clog2(FDEPTH + 1);
    localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

    logic [1:0]          w_req_vld;
    logic [1:0][W-1:0]   w_req_a;
    logic [1:0][W-1:0]   w_req_b;
    logic [1:0]          w_req_cin;
    logic [1:0]          w_rsp_rdy;
    logic [1:0]          w_elig;
    logic [1:0]          w_gnt;
    logic [1:0]          w_wr;
    logic [1:0]          w_pop;
    logic [1:0]          w_rsp_vld;
    logic [1:0][W:0]     w_head;

    logic                w_issue;
    req_id_t             w_issue_id;
    logic [W-1:0]        w_add_a;
    logic [W-1:0]        w_add_b;
    logic                w_add_cin;
    logic [W-1:0]        w_add_sum;
    logic                w_add_cout;
    logic [W:0]          w_res;

    req_id_t             r_prio;
    logic [LAT-1:0]      r_tag_vld;
    req_id_t             r_tag_id [LAT];

    assign w_req_vld = {req1_valid, req0_valid};
    assign w_req_a   = {req1_a, req0_a};
    assign w_req_b   = {req1_b, req0_b};
    assign w_req_cin = {req1_cin, req0_cin};
    assign w_rsp_rdy = {rsp1_ready, rsp0_ready};

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        w_gnt = 2'b00;
        if (rst_n) begin
            if (&w_elig) begin
                w_gnt = (r_prio == REQ1) ? 2'b10 : 2'b01;
            end else begin
                w_gnt = w_elig;
            end
        end
    end

    assign w_issue    = |w_gnt;
    assign w_issue_id = w_gnt[1] ? REQ1 : REQ0;
    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        if (w_gnt[0]) begin
            w_add_a   = w_req_a[0];
            w_add_b   = w_req_b[0];
            w_add_cin = w_req_cin[0];
        end else if (w_gnt[1]) begin
            w_add_a   = w_req_a[1];
            w_add_b   = w_req_b[1];
            w_add_cin = w_req_cin[1];
        end
    end

    pipelined_ripple_carry #(
        .W   (W),
        .LAT (LAT)
    ) u_adder (
        .clk       (clk),
        .A         (w_add_a),
        .B         (w_add_b),
        .carry_in  (w_add_cin),
        .Sum       (w_add_sum),
        .carry_out (w_add_cout)
    );

    assign w_res = {w_add_cout, w_add_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= REQ0;
        end else if (w_issue) begin
            r_prio <= other_req(w_issue_id);
        end
    end

    // Tag pipe runs in lockstep with the adder; the last stage lines up with Sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag_id[i] <= REQ0;
            end
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_issue_id;
            for (int i = 1; i < LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    assign w_wr[0] = r_tag_vld[LAT-1] && (r_tag_id[LAT-1] == REQ0);
    assign w_wr[1] = r_tag_vld[LAT-1] && (r_tag_id[LAT-1] == REQ1);

    for (genvar n = 0; n < 2; n++) begin : g_req
        logic [W:0]    r_mem [FDEPTH];
        logic [PW-1:0] r_wptr;
        logic [PW-1:0] r_rptr;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] r_credit;

        // Credit covers in-flight plus buffered results, so the FIFO can never overflow.
        assign w_elig[n]    = w_req_vld[n] && (r_credit < CW'(FDEPTH));
        assign w_rsp_vld[n] = (r_cnt != '0);
        assign w_pop[n]     = w_rsp_vld[n] && w_rsp_rdy[n];
        assign w_head[n]    = w_rsp_vld[n] ? r_mem[r_rptr] : '0;

        always_ff @(posedge clk) begin
            if (w_wr[n]) begin
                r_mem[r_wptr] <= w_res;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_cnt    <= '0;
                r_credit <= '0;
            end else begin
                if (w_wr[n]) begin
                    r_wptr <= (r_wptr == PW'(FDEPTH - 1)) ? '0 : r_wptr + PW'(1);
                end
                if (w_pop[n]) begin
                    r_rptr <= (r_rptr == PW'(FDEPTH - 1)) ? '0 : r_rptr + PW'(1);
                end
                case ({w_wr[n], w_pop[n]})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
                case ({w_gnt[n], w_pop[n]})
                    2'b10:   r_credit <= r_credit + CW'(1);
                    2'b01:   r_credit <= r_credit - CW'(1);
                    default: r_credit <= r_credit;
                endcase
            end
        end

        a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(w_wr[n] && (r_cnt == CW'(FDEPTH))));
    end

    assign rsp0_valid            = w_rsp_vld[0];
    assign rsp1_valid            = w_rsp_vld[1];
    assign {rsp0_cout, rsp0_sum} = w_head[0];
    assign {rsp1_cout, rsp1_sum} = w_head[1];
    assign busy                  = (|r_tag_vld) | (|w_rsp_vld);

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter W, default 4, operand and sum width.
REQ-002 Parameter LAT, default 4, register stages in the shared adder, input to Sum/carry_out.
REQ-003 Parameter FDEPTH, default 2, result FIFO entries per requester.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) offers an operation.
REQ-007 reqN_ready  out  1  operation accepted this cycle when valid and ready are both high.
REQ-008 reqN_a, reqN_b  in  W  operands.
REQ-009 reqN_cin  in  1  carry-in.
REQ-010 rspN_valid  out  1  result available at FIFO head.
REQ-011 rspN_ready  in  1  requester N consumes the head result.
REQ-012 rspN_sum  out  W  head result sum.
REQ-013 rspN_cout  out  1  head result carry-out.
REQ-014 busy  out  1  high while any operation is in flight or any FIFO is non-empty.

Function
REQ-015 A requester is eligible when reqN_valid=1 and credit_N < FDEPTH; credit_N counts in-flight operations plus FIFO entries.
REQ-016 At most one grant per cycle, round-robin: priority goes to the requester not granted last; after reset, requester 0 has priority.
REQ-017 reqN_ready is combinational, high only for the granted requester; reqN_ready never depends on rspN_ready of the other requester.
REQ-018 On a grant, operands and cin of the winner drive the adder in the same cycle; with no grant, the adder inputs are zero.
REQ-019 A tag pipeline of LAT stages (valid bit, requester id) tracks each issue in lockstep with the adder.
REQ-020 When the tag leaves stage LAT valid, {carry_out, Sum} is written into FIFO[id] at that edge; a handshake in cycle t gives rspN_valid=1 in cycle t+LAT+1.
REQ-021 Results are returned to each requester in issue order; arithmetic is {cout,sum} = a + b + cin, modulo 2^(W+1).
REQ-022 rspN_valid = FIFO N non-empty; the head pops when rspN_valid and rspN_ready are both high.
REQ-023 credit_N increments on issue and decrements on pop; a simultaneous issue and pop leaves it unchanged.
REQ-024 A write to a full FIFO is impossible by construction; an assertion flags any occurrence.
REQ-025 Pipeline never stalls; backpressure acts only through credits, so a blocked requester never blocks the other.

Reset
REQ-026 With rst_n low: reqN_ready=0, rspN_valid=0, rspN_sum=0, rspN_cout=0, busy=0, all credits 0, tag valids 0, FIFOs empty, priority pointer = requester 0.
REQ-027 Reset mid-operation discards all in-flight and buffered results; no stale response appears after rst_n rises.
REQ-028 The first grant is possible in the first cycle with rst_n high.

Structure
REQ-029 W, LAT and FDEPTH defaults plus the requester-id type belong in a shared package used by the block and its bench.
REQ-030 One sub-module, the existing pipelined_ripple_carry adder (clk, A, B, carry_in, Sum, carry_out); the arbiter, tag pipeline, credits and FIFOs stay in adder_arbiter.

Verification
REQ-031 Single op, req0 a=5 b=2 cin=0 -> rsp0 sum=7 cout=0, rsp0_valid exactly LAT+1 cycles after handshake; rsp1 untouched.
REQ-032 Both requesters valid continuously, rsp ready=1 -> grants 0,1,0,1...; req1 a=15 b=1 cin=1 -> rsp1 sum=1 cout=1.
REQ-033 rsp0_ready=0, req0 valid continuously -> exactly FDEPTH=2 req0 handshakes, then req0_ready=0 while req1 still served; raising rsp0_ready resumes req0.
REQ-034 Ordering, req0 issues 1+1, 2+2, 3+3 back-to-back -> rsp0 returns 2, 4, 6 in that order.
REQ-035 credit0=1 with a pop and a new req0 issue in the same cycle -> credit0 stays 1, no lost or duplicated result.
REQ-036 rst_n low with 3 ops in flight -> all outputs at reset values immediately; after release, no response appears until a new issue.
